// File: rtl/lfsr_rand_pkg.sv
// Shared types, default constants and round-robin helper for the LFSR random-value server.
package lfsr_rand_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GATHER  = 2'd1,
    DELIVER = 2'd2
  } state_t;

  localparam logic [7:0] DEFAULT_TAPS = 8'hB8;
  localparam logic [7:0] DEFAULT_SEED = 8'h80;

  // Index of the first set request at or after ptr, wrapping over num requesters.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                         input int unsigned num);
    logic [2:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!found && (k < int'(num))) begin
        int unsigned cand;
        cand = (int'(ptr) + k) % num;
        if (req[cand]) begin
          idx   = 3'(cand);
          found = 1'b1;
        end
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR that shifts left one bit per step; a zero load value falls back to SEED.
module lfsr_core
  import lfsr_rand_pkg::*;
#(
  parameter int              LFSR_W = 8,
  parameter logic [LFSR_W-1:0] TAPS = DEFAULT_TAPS,
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic              out_bit,
  output logic [LFSR_W-1:0] state
);

  logic fb;

  assign out_bit = state[LFSR_W-1];
  assign fb      = ^(state & TAPS);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else if (load) begin
      state <= (load_val == '0) ? SEED : load_val;
    end else if (step) begin
      state <= {state[LFSR_W-2:0], fb};
    end
  end

endmodule

// File: rtl/lfsr_rand_server.sv
// Round-robin server handing out VALUE_W fresh LFSR bits per request.
// Optional statistics counters are enabled by defining LFSR_RAND_SERVER_STATS_EN.
module lfsr_rand_server
  import lfsr_rand_pkg::*;
#(
  parameter int                NUM_REQ = 2,
  parameter int                VALUE_W = 3,
  parameter int                LFSR_W  = 8,
  parameter logic [LFSR_W-1:0] TAPS    = DEFAULT_TAPS,
  parameter logic [LFSR_W-1:0] SEED    = DEFAULT_SEED
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [VALUE_W-1:0] value,
  output logic               value_valid,
  input  logic               seed_load,
  input  logic [LFSR_W-1:0]  seed_in,
  output logic               busy
`ifdef LFSR_RAND_SERVER_STATS_EN
  ,
  output logic [15:0]        deliver_count,
  output logic [7:0]         abort_count
`endif
);

  localparam int CNT_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;

  state_t             fsm;
  logic [2:0]         rr_ptr;
  logic [2:0]         gidx;
  logic [CNT_W-1:0]   cnt;
  logic [VALUE_W-1:0] shift_buf;
  logic [LFSR_W-1:0]  lfsr;
  logic               out_bit;
  logic [7:0]         req_ext;
  logic [2:0]         pick;
  logic [7:0]         pick_onehot;
  logic               owner_live;
  logic               step;
  logic               load;

  assign req_ext     = 8'(req);
  assign pick        = rr_pick(req_ext, rr_ptr, NUM_REQ);
  assign pick_onehot = 8'(1) << pick;
  assign owner_live  = req_ext[gidx];
  // A dropped request aborts before the step, so the abort cycle consumes no bit.
  assign step        = (fsm == GATHER) && owner_live;
  assign load        = (fsm == IDLE) && seed_load;
  assign busy        = (fsm != IDLE);

  lfsr_core #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .SEED   (SEED)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .step     (step),
    .load     (load),
    .load_val (seed_in),
    .out_bit  (out_bit),
    .state    (lfsr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm         <= IDLE;
      rr_ptr      <= '0;
      gidx        <= '0;
      cnt         <= '0;
      shift_buf   <= '0;
      grant       <= '0;
      value       <= '0;
      value_valid <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      unique case (fsm)
        IDLE: begin
          // grant stays visible through the value_valid cycle, then follows arbitration.
          if (!seed_load && (|req)) begin
            gidx  <= pick;
            grant <= pick_onehot[NUM_REQ-1:0];
            cnt   <= '0;
            fsm   <= GATHER;
          end else begin
            grant <= '0;
          end
        end
        GATHER: begin
          if (!owner_live) begin
            grant <= '0;
            fsm   <= IDLE;
          end else begin
            shift_buf <= VALUE_W'({shift_buf, out_bit});
            if (cnt == CNT_W'(VALUE_W - 1)) begin
              fsm <= DELIVER;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DELIVER: begin
          value       <= shift_buf;
          value_valid <= 1'b1;
          rr_ptr      <= (gidx == 3'(NUM_REQ - 1)) ? 3'd0 : gidx + 3'd1;
          fsm         <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

`ifdef LFSR_RAND_SERVER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deliver_count <= '0;
      abort_count   <= '0;
    end else begin
      if (fsm == DELIVER) begin
        deliver_count <= deliver_count + 16'd1;
      end
      if ((fsm == GATHER) && !owner_live && (abort_count != 8'hFF)) begin
        abort_count <= abort_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: doc/lfsr_rand_server.md
Name: lfsr_rand_server

Overview:
- Shares one LFSR random-bit source between NUM_REQ requesters.
- Arbitrates round-robin and gathers VALUE_W fresh bits per request, so no bit is ever reused across values.
- Delivers each value with a one-cycle valid pulse tagged by a one-hot grant.
- Sits between the LFSR datapath and game/demo logic that needs small random numbers.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- VALUE_W, 3, bits per delivered value (1..LFSR_W).
- LFSR_W, 8, LFSR state width.
- TAPS, 8'hB8, feedback mask (x^8+x^6+x^5+x^4+1).
- SEED, 8'h80, reset seed; must be nonzero.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req  in  NUM_REQ  per-requester level request
- grant  out  NUM_REQ  one-hot owner of current transaction; 0 in IDLE
- value  out  VALUE_W  delivered random value
- value_valid  out  1  one-cycle pulse, value valid for grant owner
- seed_load  in  1  load seed_in into LFSR (honoured in IDLE only)
- seed_in  in  LFSR_W  new seed
- busy  out  1  high in GATHER or DELIVER

Behaviour:
- Reset (async, rst=1) values:
  - lfsr=SEED, state=IDLE, rr_ptr=0, grant=0, value=0, value_valid=0, busy=0, bit counter=0.
- LFSR step, applied only in GATHER:
  - out_bit = lfsr[LFSR_W-1]
  - fb = ^(lfsr & TAPS)
  - lfsr <= {lfsr[LFSR_W-2:0], fb}
  - No step in IDLE or DELIVER.
- Value assembly: shift_buf <= {shift_buf[VALUE_W-2:0], out_bit}, so the first bit becomes the MSB.
- FSM IDLE:
  - If seed_load=1: lfsr <= (seed_in==0 ? SEED : seed_in). No arbitration in that cycle.
  - Else if any req: pick the first set req at or after rr_ptr (wrapping), set grant one-hot, clear the counter, go to GATHER.
- FSM GATHER:
  - Step LFSR and shift out_bit each cycle; count 0..VALUE_W-1.
  - After VALUE_W steps, go to DELIVER.
  - If the granted req drops: abort to IDLE, discard bits (LFSR keeps its advanced state), grant=0, rr_ptr unchanged.
- FSM DELIVER (one cycle):
  - value <= shift_buf, value_valid=1, grant held.
  - rr_ptr <= (granted index+1) mod NUM_REQ.
  - Next state IDLE.
- Timing:
  - Latency from req sampled in IDLE to value_valid = VALUE_W+1 cycles.
  - Back-to-back throughput: one value per VALUE_W+2 cycles.
- Edge cases:
  - value holds its last delivered value when value_valid=0.
  - seed_load outside IDLE is ignored, not queued.
  - A req held high after delivery re-enters arbitration normally; fairness comes from rr_ptr.
  - A requester sees the result only when value_valid & grant[i].

Optional Feature:
- Macro LFSR_RAND_SERVER_STATS_EN.
- When defined:
  - Adds output deliver_count (16 bits, reset 0), +1 on each value_valid, wraps at 0xFFFF.
  - Adds output abort_count (8 bits, reset 0), +1 on each GATHER abort, saturates at 0xFF.
- When undefined: neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- Package lfsr_rand_pkg holds:
  - state enum {IDLE, GATHER, DELIVER}
  - default TAPS and SEED constants
  - a round-robin pick function (req, ptr -> index)
- One sub-module, lfsr_core: parameters LFSR_W, TAPS, SEED; inputs step, load, load_val; outputs out_bit, state.
- Arbitration, FSM and shift buffer live in lfsr_rand_server.

Test Plan:
- Reset with SEED=8'h80, then hold req=2'b01:
  - value_valid after 4 cycles with value=3'd4, grant=2'b01, LFSR=8'h04.
  - Next value=3'd0, LFSR=8'h23.
- req=2'b11 held continuously: grants alternate 01,10,01,10, one value_valid every 5 cycles, never two consecutive grants to the same requester.
- Drop req[0] in the 2nd GATHER cycle: return to IDLE, no value_valid, grant=0. With STATS_EN, abort_count=1.
- seed_load=1 with seed_in=8'h00 in IDLE: LFSR becomes 8'h80. With seed_in=8'h01 the next value=3'd0. seed_load during GATHER leaves LFSR unchanged.
- Assert rst during GATHER:
  - Outputs return to reset values immediately (async).
  - After release with req=2'b01, the first value is 3'd4 again.
- STATS_EN build, 10 deliveries: deliver_count=10. Non-STATS build compiles with the same outputs otherwise.
